// File: rtl/rv_lsu_if.sv
// Data-bus interface between the load/store unit (master) and the memory side (slave).
// ttype: 0 = READ, 1 = WRITE.  tsize: 00 = BYTE, 01 = HALF, 10 = WORD.
interface master_bus_if;
  logic        bstart;
  logic        breq;
  logic        ttype;
  logic [1:0]  tsize;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        bdone;

  modport master (
    output bstart, breq, ttype, tsize, addr, wdata,
    input  rdata, bdone
  );

  modport slave (
    input  bstart, breq, ttype, tsize, addr, wdata,
    output rdata, bdone
  );
endinterface

// File: rtl/rv_lsu.sv
// rv_lsu: multi-cycle RV32 load/store unit.
// Accepts one request at a time, rejects illegal sizes and misaligned addresses
// without touching the bus, replicates store data across byte lanes and
// extracts/extends load data. Exactly one response pulse per accepted request.
// Optional bus timeout: define RV_LSU_TIMEOUT_EN to abort a bus transfer after
// TIMEOUT_CYCLES cycles without bdone (err = 10).
module rv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          LANE_ALIGNED_RDATA = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  master_bus_if.master dbus
);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_SIZE    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_err;

  logic        w_req_illegal;
  logic        w_req_misal;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;
  logic [31:0] w_store_lanes;
  logic        w_expire;

  // Request decode: size legality and alignment, looked at only in IDLE
  assign w_req_illegal = req_we ? (req_funct3[2] || (req_funct3 == 3'b011))
                                : ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                                   (req_funct3 == 3'b111));
  assign w_req_misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef RV_LSU_TIMEOUT_EN
  logic [15:0] r_cnt;

  // Bus wait counter: zero outside BUS, counts BUS cycles without bdone
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state != S_BUS) begin
      r_cnt <= '0;
    end else if (!dbus.bdone) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Expiry fires on the TIMEOUT_CYCLES-th BUS cycle still lacking bdone
  assign w_expire = (r_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign w_expire     = 1'b0;
`endif

  // Load path: move the addressed lane to bit 0, then sign/zero extend
  assign w_shifted = LANE_ALIGNED_RDATA ? (dbus.rdata >> {r_addr[1:0], 3'b000}) : dbus.rdata;

  // Extension by funct3; stores always report zero data
  always_comb begin
    w_load_data = w_shifted;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
    if (r_we) begin
      w_load_data = '0;
    end
  end

  // Store path: replicate the right-justified data across all byte lanes
  always_comb begin
    w_store_lanes = r_wdata;
    case (r_funct3[1:0])
      2'b00:   w_store_lanes = {4{r_wdata[7:0]}};
      2'b01:   w_store_lanes = {2{r_wdata[15:0]}};
      default: w_store_lanes = r_wdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and outputs; BUS/RESP outputs come only from latched values
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_err     = ERR_OK;
    dbus.bstart  = 1'b0;
    dbus.breq    = 1'b1;
    dbus.ttype   = r_we;
    dbus.tsize   = r_funct3[1:0];
    dbus.addr    = r_addr;
    dbus.wdata   = w_store_lanes;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = (w_req_illegal || w_req_misal) ? S_RESP : S_BUS;
        end
      end
      S_BUS: begin
        dbus.bstart = 1'b1;
        if (dbus.bdone || w_expire) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        resp_rdata   = r_rdata;
        resp_err     = r_err;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request latch and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= ERR_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= '0;
            r_err    <= w_req_illegal ? ERR_SIZE : (w_req_misal ? ERR_MISALIGN : ERR_OK);
          end
        end
        S_BUS: begin
          if (dbus.bdone) begin
            r_rdata <= w_load_data;
            r_err   <= ERR_OK;
          end else if (w_expire) begin
            r_rdata <= '0;
            r_err   <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Self-checking bench for rv_lsu: scoreboard of expected responses plus
// cycle-by-cycle bus checks. Timeout cases run when RV_LSU_TIMEOUT_EN is defined.
module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  master_bus_if dbus();

  rv_lsu #(.TIMEOUT_CYCLES(4), .LANE_ALIGNED_RDATA(1'b1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dbus       (dbus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Response monitor: every response pulse must match the oldest expectation
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_rdata", resp_rdata, mon_e.rdata);
        chk("resp_err", {30'd0, resp_err}, {30'd0, mon_e.err});
        chk("resp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // One request: drive, act as bus slave for k BUS cycles, expect the response
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int k, input logic give_done,
                         input logic [31:0] bus_rdata, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_err);
    int   t0;
    logic is_err;
    exp_t e;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    t0         = cyc;
    is_err     = (exp_err == 2'b01) || (exp_err == 2'b11);
    e.rdata    = exp_rdata;
    e.err      = exp_err;
    e.cyc      = t0 + (is_err ? 1 : k + 1);
    sb.push_back(e);
    if (!is_err) begin
      for (int i = 1; i <= k; i++) begin
        @(negedge clk);
        req_we     = ~we;
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        chk("bstart", {31'd0, dbus.bstart}, 32'd1);
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        chk("ttype", {31'd0, dbus.ttype}, {31'd0, we});
        chk("tsize", {30'd0, dbus.tsize}, {30'd0, f3[1:0]});
        chk("addr", dbus.addr, addr);
        if (we) chk("wdata", dbus.wdata, exp_wdata);
        if (give_done && i == k) begin
          dbus.bdone = 1'b1;
          dbus.rdata = bus_rdata;
        end else begin
          dbus.bdone = 1'b0;
          dbus.rdata = $urandom;
        end
      end
    end
    @(negedge clk);
    dbus.bdone = 1'b0;
    req_valid  = 1'b0;
    chk("bstart_resp", {31'd0, dbus.bstart}, 32'd0);
    chk("resp_valid", {31'd0, resp_valid}, 32'd1);
    $display("TXN we=%0d f3=%03b addr=0x%08h exp_rdata=0x%08h exp_err=%02b got_rdata=0x%08h got_err=%02b",
             we, f3, addr, exp_rdata, exp_err, resp_rdata, resp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    dbus.bdone = 1'b0;
    dbus.rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {30'd0, resp_err}, 32'd0);
    chk("rst_bstart", {31'd0, dbus.bstart}, 32'd0);
    chk("rst_breq", {31'd0, dbus.breq}, 32'd1);
    rst = 1'b0;

    //       we    f3      addr          wdata         k  done  bus_rdata     exp_wdata     exp_rdata     err
    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0,        2, 1'b1, 32'h80FF_1234, 32'h0,        32'hFFFF_FF80, 2'b00);
    run_txn(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 1, 1'b1, 32'h5555_5555, 32'hBEEF_BEEF, 32'h0,        2'b00);
    run_txn(1'b0, 3'b010, 32'h0000_0101, 32'h0,        1, 1'b1, 32'h0,        32'h0,        32'h0,        2'b01);
    run_txn(1'b0, 3'b101, 32'h0000_0100, 32'h0,        3, 1'b1, 32'h0000_F00D, 32'h0,        32'h0000_F00D, 2'b00);
    run_txn(1'b0, 3'b011, 32'h0000_0000, 32'h0,        1, 1'b1, 32'h0,        32'h0,        32'h0,        2'b11);
    run_txn(1'b1, 3'b100, 32'h0000_0000, 32'h1234_5678, 1, 1'b1, 32'h0,        32'h0,        32'h0,        2'b11);
    run_txn(1'b1, 3'b000, 32'h0000_0003, 32'h1234_56A5, 2, 1'b1, 32'h0,        32'hA5A5_A5A5, 32'h0,        2'b00);
    run_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0,        1, 1'b1, 32'h8001_0000, 32'h0,        32'hFFFF_8001, 2'b00);
    run_txn(1'b0, 3'b100, 32'h0000_0101, 32'h0,        2, 1'b1, 32'h0000_C300, 32'h0,        32'h0000_00C3, 2'b00);
    run_txn(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0,        1, 1'b1, 32'hCAFE_F00D, 32'h0,        32'hCAFE_F00D, 2'b00);
    run_txn(1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 2, 1'b1, 32'h0,        32'h1122_3344, 32'h0,        2'b00);
    run_txn(1'b1, 3'b001, 32'h0000_0203, 32'h0,        1, 1'b1, 32'h0,        32'h0,        32'h0,        2'b01);
    run_txn(1'b1, 3'b111, 32'h0000_0000, 32'h0,        1, 1'b1, 32'h0,        32'h0,        32'h0,        2'b11);
    run_txn(1'b0, 3'b110, 32'h0000_0000, 32'h0,        1, 1'b1, 32'h0,        32'h0,        32'h0,        2'b11);

`ifdef RV_LSU_TIMEOUT_EN
    run_txn(1'b0, 3'b010, 32'h0000_0400, 32'h0,        4, 1'b0, 32'h0,        32'h0,        32'h0,        2'b10);
    run_txn(1'b0, 3'b010, 32'h0000_0400, 32'h0,        4, 1'b1, 32'h1357_9BDF, 32'h0,        32'h1357_9BDF, 2'b00);
`endif

    // Reset during BUS: the request is dropped silently
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0040;
    req_wdata  = 32'hA5A5_0F0F;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_bstart_before", {31'd0, dbus.bstart}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_bstart", {31'd0, dbus.bstart}, 32'd0);
    chk("rst_mid_resp", {31'd0, resp_valid}, 32'd0);
    $display("TXN reset during BUS, request dropped");
    repeat (3) begin
      @(negedge clk);
      chk("rst_idle_bstart", {31'd0, dbus.bstart}, 32'd0);
    end
    run_txn(1'b1, 3'b010, 32'h0000_0044, 32'hCAFE_BABE, 1, 1'b1, 32'h0, 32'hCAFE_BABE, 32'h0, 2'b00);

    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
